// File: rtl/put_param_pkg.sv
// -----------------------------------------------------------------------------
// put_param_pkg
// Shared configuration for the put_param block. It holds the default regfile
// geometry, the command op codes, the FSM state encodings, the state-word
// field layout and a small helper for the saturating position increment.
// -----------------------------------------------------------------------------
package put_param_pkg;

    // Default regfile geometry
    localparam int PP_ADDR_W = 12;
    localparam int PP_DEPTH  = 4096;

    // Block enable code: the block only accepts commands while enabled
    localparam logic [2:0] EN_CODE = 3'b010;

    // Command op codes
    typedef enum logic [1:0] {
        OP_PUSH   = 2'b00,
        OP_UPDATE = 2'b01,
        OP_INIT   = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    // FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_CHILD  = 2'd1,
        ST_WR_PARENT = 2'd2,
        ST_WR_UPD    = 2'd3
    } state_t;

    // State word layout: {position, back_addr, over}
    localparam int POS_W    = 5;
    localparam int OVER_BIT = 0;
    localparam int BACK_LSB = 1;
    localparam int POS_LSB  = PP_ADDR_W + 1;

    localparam logic [POS_W-1:0] POS_MAX = '1;

    // Parent position: one step deeper, pinned at the largest encodable value
    function automatic logic [POS_W-1:0] pos_inc_sat(input logic [POS_W-1:0] pos);
        return (pos == POS_MAX) ? pos : pos + POS_W'(1);
    endfunction

endpackage

// File: rtl/put_param.sv
// -----------------------------------------------------------------------------
// put_param
// Accepts PUSH / UPDATE / INIT commands and turns each one into a short burst
// of register-file write strobes towards two regfiles (InexRecur and state).
//
//   PUSH   : child written at the next free address, then the parent state
//            word is rewritten with position+1 (saturating).
//   UPDATE : one state-word write at the target address.
//   INIT   : root entry written at address 0, pointer restarts at 1.
//
// Ports
//   clk, rst_n                     clock / async active-low reset
//   en_put_param                   block enable (active when 3'b010)
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_op_i, cmd_param_i,
//   cmd_addr_i, cmd_back_addr_i,
//   cmd_position_i, cmd_over_i     command fields, latched at acceptance
//   we_reg_InexRecur_o, w_reg_InexRecur_addr_o, w_reg_InexRecur_data_o
//                                  InexRecur write port (registered)
//   we_reg_state_o, w_reg_state_addr_o, w_reg_state_data_o
//                                  state write port (registered)
//   done_o                         one-cycle completion pulse
//   child_addr_o                   address of the last child written
//   wr_ptr_o, full_o, overflow_o   allocation status
// -----------------------------------------------------------------------------
module put_param
    import put_param_pkg::*;
#(
    parameter int ADDR_W = PP_ADDR_W,
    parameter int DEPTH  = PP_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              en_put_param,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [31:0]             cmd_param_i,
    input  logic [ADDR_W-1:0]       cmd_addr_i,
    input  logic [ADDR_W-1:0]       cmd_back_addr_i,
    input  logic [POS_W-1:0]        cmd_position_i,
    input  logic                    cmd_over_i,
    output logic                    we_reg_InexRecur_o,
    output logic [ADDR_W-1:0]       w_reg_InexRecur_addr_o,
    output logic [31:0]             w_reg_InexRecur_data_o,
    output logic                    we_reg_state_o,
    output logic [ADDR_W-1:0]       w_reg_state_addr_o,
    output logic [POS_W+ADDR_W:0]   w_reg_state_data_o,
    output logic                    done_o,
    output logic [ADDR_W-1:0]       child_addr_o,
    output logic [ADDR_W-1:0]       wr_ptr_o,
    output logic                    full_o,
    output logic                    overflow_o
);

    localparam int STATE_W = POS_W + ADDR_W + 1;
    localparam int CNT_W   = ADDR_W + 1;

    state_t state, next_state;

    // Command fields kept for the parent write, which happens after acceptance
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] back_q;
    logic [POS_W-1:0]  pos_q;
    logic              over_q;
    op_t               op_q;

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] child_q;
    logic              overflow_q;

    // Registered write ports and their next values
    logic               inex_we_q,   inex_we_d;
    logic [ADDR_W-1:0]  inex_addr_q, inex_addr_d;
    logic [31:0]        inex_data_q, inex_data_d;
    logic               st_we_q,     st_we_d;
    logic [ADDR_W-1:0]  st_addr_q,   st_addr_d;
    logic [STATE_W-1:0] st_data_q,   st_data_d;
    logic               done_q,      done_d;

    op_t  op_in;
    logic full;
    logic accept;

    assign op_in  = op_t'(cmd_op_i);
    assign full   = (count == CNT_W'(DEPTH));
    assign accept = cmd_valid_i & cmd_ready_o;

    // Ready is gated by rst_n so that every output reads 0 while in reset
    assign cmd_ready_o = rst_n & (state == ST_IDLE) & (en_put_param == EN_CODE);

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: each combinational block assigns defaults first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op_in)
                        OP_INIT: next_state = ST_WR_CHILD;
                        OP_PUSH: next_state = full ? ST_WR_UPD : ST_WR_CHILD;
                        // UPDATE writes in WR_UPD; reserved ops and a PUSH
                        // while full also pass through it to emit done_o
                        default: next_state = ST_WR_UPD;
                    endcase
                end
            end
            ST_WR_CHILD:  next_state = (op_q == OP_PUSH) ? ST_WR_PARENT : ST_IDLE;
            ST_WR_PARENT: next_state = ST_IDLE;
            ST_WR_UPD:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Output values for the cycle spent in next_state. WR_CHILD and WR_UPD are
    // only entered from IDLE, so they read the live command fields and the
    // current count; WR_PARENT reads the fields latched at acceptance.
    always_comb begin
        inex_we_d   = 1'b0;
        inex_addr_d = inex_addr_q;
        inex_data_d = inex_data_q;
        st_we_d     = 1'b0;
        st_addr_d   = st_addr_q;
        st_data_d   = st_data_q;
        done_d      = 1'b0;
        unique case (next_state)
            ST_WR_CHILD: begin
                inex_we_d   = 1'b1;
                st_we_d     = 1'b1;
                inex_data_d = cmd_param_i;
                if (op_in == OP_INIT) begin
                    inex_addr_d = '0;
                    st_addr_d   = '0;
                    st_data_d   = '0;
                    done_d      = 1'b1;
                end else begin
                    inex_addr_d = count[ADDR_W-1:0];
                    st_addr_d   = count[ADDR_W-1:0];
                    st_data_d   = {POS_W'(0), cmd_addr_i, 1'b0};
                end
            end
            ST_WR_PARENT: begin
                st_we_d   = 1'b1;
                st_addr_d = addr_q;
                st_data_d = {pos_inc_sat(pos_q), back_q, over_q};
                done_d    = 1'b1;
            end
            ST_WR_UPD: begin
                done_d = 1'b1;
                if (op_in == OP_UPDATE) begin
                    st_we_d   = 1'b1;
                    st_addr_d = cmd_addr_i;
                    st_data_d = {cmd_position_i, cmd_back_addr_i, cmd_over_i};
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inex_we_q   <= 1'b0;
            inex_addr_q <= '0;
            inex_data_q <= '0;
            st_we_q     <= 1'b0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            back_q      <= '0;
            pos_q       <= '0;
            over_q      <= 1'b0;
            op_q        <= OP_PUSH;
            count       <= '0;
            child_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            inex_we_q   <= inex_we_d;
            inex_addr_q <= inex_addr_d;
            inex_data_q <= inex_data_d;
            st_we_q     <= st_we_d;
            st_addr_q   <= st_addr_d;
            st_data_q   <= st_data_d;
            done_q      <= done_d;
            if (accept) begin
                addr_q <= cmd_addr_i;
                back_q <= cmd_back_addr_i;
                pos_q  <= cmd_position_i;
                over_q <= cmd_over_i;
                op_q   <= op_in;
                if (op_in == OP_INIT) begin
                    count      <= CNT_W'(1);
                    child_q    <= '0;
                    overflow_q <= 1'b0;
                end else if (op_in == OP_PUSH) begin
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        count   <= count + CNT_W'(1);
                        child_q <= count[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    assign we_reg_InexRecur_o     = inex_we_q;
    assign w_reg_InexRecur_addr_o = inex_addr_q;
    assign w_reg_InexRecur_data_o = inex_data_q;
    assign we_reg_state_o         = st_we_q;
    assign w_reg_state_addr_o     = st_addr_q;
    assign w_reg_state_data_o     = st_data_q;
    assign done_o                 = done_q;
    assign child_addr_o           = child_q;
    assign wr_ptr_o               = count[ADDR_W-1:0];
    assign full_o                 = full;
    assign overflow_o             = overflow_q;

endmodule

// File: tb/tb_put_param.sv
// -----------------------------------------------------------------------------
// tb_put_param
// Directed bench for put_param: reset state, INIT, PUSH, UPDATE, saturation,
// reserved op, enable drop mid-command, fill to full with overflow, and reset
// in the middle of a PUSH.
// -----------------------------------------------------------------------------
module tb_put_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  en_put_param;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_param_i;
    logic [11:0] cmd_addr_i;
    logic [11:0] cmd_back_addr_i;
    logic [4:0]  cmd_position_i;
    logic        cmd_over_i;
    logic        we_reg_InexRecur_o;
    logic [11:0] w_reg_InexRecur_addr_o;
    logic [31:0] w_reg_InexRecur_data_o;
    logic        we_reg_state_o;
    logic [11:0] w_reg_state_addr_o;
    logic [17:0] w_reg_state_data_o;
    logic        done_o;
    logic [11:0] child_addr_o;
    logic [11:0] wr_ptr_o;
    logic        full_o;
    logic        overflow_o;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [1:0] PUSH = 2'b00, UPD = 2'b01, INIT = 2'b10, RSVD = 2'b11;

    put_param dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .en_put_param           (en_put_param),
        .cmd_valid_i            (cmd_valid_i),
        .cmd_ready_o            (cmd_ready_o),
        .cmd_op_i               (cmd_op_i),
        .cmd_param_i            (cmd_param_i),
        .cmd_addr_i             (cmd_addr_i),
        .cmd_back_addr_i        (cmd_back_addr_i),
        .cmd_position_i         (cmd_position_i),
        .cmd_over_i             (cmd_over_i),
        .we_reg_InexRecur_o     (we_reg_InexRecur_o),
        .w_reg_InexRecur_addr_o (w_reg_InexRecur_addr_o),
        .w_reg_InexRecur_data_o (w_reg_InexRecur_data_o),
        .we_reg_state_o         (we_reg_state_o),
        .w_reg_state_addr_o     (w_reg_state_addr_o),
        .w_reg_state_data_o     (w_reg_state_data_o),
        .done_o                 (done_o),
        .child_addr_o           (child_addr_o),
        .wr_ptr_o               (wr_ptr_o),
        .full_o                 (full_o),
        .overflow_o             (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Step past the next rising edge; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, and return one step after
    // the accepting edge with valid already dropped.
    task automatic send(input logic [1:0] op, input logic [31:0] param,
                        input logic [11:0] addr, input logic [11:0] back,
                        input logic [4:0] pos, input logic over);
        int waited = 0;
        cmd_op_i        = op;
        cmd_param_i     = param;
        cmd_addr_i      = addr;
        cmd_back_addr_i = back;
        cmd_position_i  = pos;
        cmd_over_i      = over;
        cmd_valid_i     = 1'b1;
        while (!cmd_ready_o && waited < 20) begin
            tick();
            waited++;
        end
        if (!cmd_ready_o) check("accept_timeout", 32'(cmd_ready_o), 32'd1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_ready"},     32'(cmd_ready_o),            32'd0);
        check({phase, "_we_inex"},   32'(we_reg_InexRecur_o),     32'd0);
        check({phase, "_inex_addr"}, 32'(w_reg_InexRecur_addr_o), 32'd0);
        check({phase, "_inex_data"}, w_reg_InexRecur_data_o,      32'd0);
        check({phase, "_we_state"},  32'(we_reg_state_o),         32'd0);
        check({phase, "_st_addr"},   32'(w_reg_state_addr_o),     32'd0);
        check({phase, "_st_data"},   32'(w_reg_state_data_o),     32'd0);
        check({phase, "_done"},      32'(done_o),                 32'd0);
        check({phase, "_child"},     32'(child_addr_o),           32'd0);
        check({phase, "_wr_ptr"},    32'(wr_ptr_o),               32'd0);
        check({phase, "_full"},      32'(full_o),                 32'd0);
        check({phase, "_overflow"},  32'(overflow_o),             32'd0);
    endtask

    initial begin
        int pushes;

        rst_n           = 1'b0;
        en_put_param    = 3'b010;
        cmd_valid_i     = 1'b0;
        cmd_op_i        = 2'b00;
        cmd_param_i     = '0;
        cmd_addr_i      = '0;
        cmd_back_addr_i = '0;
        cmd_position_i  = '0;
        cmd_over_i      = 1'b0;

        // Reset state
        #12;
        check_all_zero("rst");
        tick();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(cmd_ready_o), 32'd1);

        // INIT
        send(INIT, 32'h01020304, 12'd0, 12'd0, 5'd0, 1'b0);
        check("init_we_inex",   32'(we_reg_InexRecur_o),     32'd1);
        check("init_inex_addr", 32'(w_reg_InexRecur_addr_o), 32'd0);
        check("init_inex_data", w_reg_InexRecur_data_o,      32'h01020304);
        check("init_we_state",  32'(we_reg_state_o),         32'd1);
        check("init_st_data",   32'(w_reg_state_data_o),     32'd0);
        check("init_wr_ptr",    32'(wr_ptr_o),               32'd1);
        check("init_done",      32'(done_o),                 32'd1);
        check("init_busy",      32'(cmd_ready_o),            32'd0);
        tick();
        check("init_we_off",    32'(we_reg_InexRecur_o),     32'd0);
        check("init_done_off",  32'(done_o),                 32'd0);
        check("init_data_hold", w_reg_InexRecur_data_o,      32'h01020304);
        check("init_ready",     32'(cmd_ready_o),            32'd1);

        // PUSH under root
        send(PUSH, 32'hAABBCCDD, 12'd0, 12'd0, 5'd3, 1'b0);
        check("push_we_inex",   32'(we_reg_InexRecur_o),     32'd1);
        check("push_inex_addr", 32'(w_reg_InexRecur_addr_o), 32'd1);
        check("push_inex_data", w_reg_InexRecur_data_o,      32'hAABBCCDD);
        check("push_we_state",  32'(we_reg_state_o),         32'd1);
        check("push_st_addr",   32'(w_reg_state_addr_o),     32'd1);
        check("push_st_data",   32'(w_reg_state_data_o),     32'd0);
        check("push_done_early",32'(done_o),                 32'd0);
        check("push_wr_ptr",    32'(wr_ptr_o),               32'd2);
        tick();
        check("par_we_inex",    32'(we_reg_InexRecur_o),     32'd0);
        check("par_we_state",   32'(we_reg_state_o),         32'd1);
        check("par_st_addr",    32'(w_reg_state_addr_o),     32'd0);
        check("par_st_data",    32'(w_reg_state_data_o),     32'h08000);
        check("par_done",       32'(done_o),                 32'd1);
        check("par_child",      32'(child_addr_o),           32'd1);
        tick();
        check("par_we_off",     32'(we_reg_state_o),         32'd0);

        // UPDATE
        send(UPD, 32'hDEADBEEF, 12'd5, 12'd2, 5'd7, 1'b1);
        check("upd_we_inex",    32'(we_reg_InexRecur_o),     32'd0);
        check("upd_we_state",   32'(we_reg_state_o),         32'd1);
        check("upd_st_addr",    32'(w_reg_state_addr_o),     32'd5);
        check("upd_st_data",    32'(w_reg_state_data_o),     32'h0E005);
        check("upd_done",       32'(done_o),                 32'd1);
        check("upd_wr_ptr",     32'(wr_ptr_o),               32'd2);
        tick();
        check("upd_we_off",     32'(we_reg_state_o),         32'd0);
        check("upd_data_hold",  32'(w_reg_state_data_o),     32'h0E005);

        // PUSH with position at its ceiling
        send(PUSH, 32'h11223344, 12'd1, 12'd3, 5'd31, 1'b1);
        check("sat_inex_addr",  32'(w_reg_InexRecur_addr_o), 32'd2);
        check("sat_child_word", 32'(w_reg_state_data_o),     32'h00002);
        tick();
        check("sat_st_addr",    32'(w_reg_state_addr_o),     32'd1);
        check("sat_st_data",    32'(w_reg_state_data_o),     32'h3E007);
        check("sat_child",      32'(child_addr_o),           32'd2);
        tick();

        // Reserved op
        send(RSVD, 32'hFFFFFFFF, 12'd9, 12'd9, 5'd9, 1'b1);
        check("rsv_we_inex",    32'(we_reg_InexRecur_o),     32'd0);
        check("rsv_we_state",   32'(we_reg_state_o),         32'd0);
        check("rsv_done",       32'(done_o),                 32'd1);
        check("rsv_wr_ptr",     32'(wr_ptr_o),               32'd3);
        tick();
        check("rsv_done_off",   32'(done_o),                 32'd0);

        // Enable dropped right after acceptance: sequence still completes
        send(PUSH, 32'h55667788, 12'd2, 12'd0, 5'd0, 1'b0);
        en_put_param = 3'b000;
        check("en_child_we",    32'(we_reg_InexRecur_o),     32'd1);
        check("en_child_addr",  32'(w_reg_InexRecur_addr_o), 32'd3);
        tick();
        check("en_par_we",      32'(we_reg_state_o),         32'd1);
        check("en_par_data",    32'(w_reg_state_data_o),     32'h02000);
        check("en_par_done",    32'(done_o),                 32'd1);
        tick();
        check("en_off_ready",   32'(cmd_ready_o),            32'd0);
        en_put_param = 3'b010;
        #1;
        check("en_on_ready",    32'(cmd_ready_o),            32'd1);

        // Fill the remaining entries (4 used so far)
        pushes = 0;
        while (!full_o && pushes < 5000) begin
            send(PUSH, 32'(pushes), 12'd0, 12'd0, 5'd0, 1'b0);
            tick();
            tick();
            pushes++;
        end
        check("fill_count",     32'(pushes),                 32'd4092);
        check("fill_full",      32'(full_o),                 32'd1);
        check("fill_wr_ptr",    32'(wr_ptr_o),               32'd0);
        check("fill_no_ovf",    32'(overflow_o),             32'd0);

        // PUSH while full
        send(PUSH, 32'h12345678, 12'd0, 12'd0, 5'd0, 1'b0);
        check("ovf_we_inex",    32'(we_reg_InexRecur_o),     32'd0);
        check("ovf_we_state",   32'(we_reg_state_o),         32'd0);
        check("ovf_done",       32'(done_o),                 32'd1);
        check("ovf_flag",       32'(overflow_o),             32'd1);
        check("ovf_wr_ptr",     32'(wr_ptr_o),               32'd0);
        tick();
        check("ovf_sticky",     32'(overflow_o),             32'd1);

        // INIT clears overflow and restarts allocation
        send(INIT, 32'h0A0B0C0D, 12'd0, 12'd0, 5'd0, 1'b0);
        check("reinit_ovf",     32'(overflow_o),             32'd0);
        check("reinit_wr_ptr",  32'(wr_ptr_o),               32'd1);
        check("reinit_full",    32'(full_o),                 32'd0);
        tick();

        // Reset while in WR_CHILD
        send(PUSH, 32'hCAFEF00D, 12'd0, 12'd1, 5'd1, 1'b0);
        check("mid_we_inex",    32'(we_reg_InexRecur_o),     32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick();
        check("mid_rst_we_st",  32'(we_reg_state_o),         32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(cmd_ready_o),            32'd1);
        tick();
        check("post_rst_we",    32'(we_reg_state_o),         32'd0);
        check("post_rst_done",  32'(done_o),                 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/put_param.md
PUT_PARAM -- requirements
Module: put_param

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, regfile address width; DEPTH, default 4096, regfile entries.
REQ-002 SHALL have ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_put_param  in  3  block enable, active only when 3'b010
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_op_i  in  2  00 PUSH, 01 UPDATE, 10 INIT, 11 reserved
cmd_param_i  in  32  {i,z,k,l}, 8 bits each, i in [31:24]
cmd_addr_i  in  12  PUSH: parent address; UPDATE: target address
cmd_back_addr_i  in  12  back address written into the parent/target state word
cmd_position_i  in  5  execution position
cmd_over_i  in  1  completion flag
we_reg_InexRecur_o  out  1  InexRecur write enable
w_reg_InexRecur_addr_o  out  12  InexRecur write address
w_reg_InexRecur_data_o  out  32  InexRecur write data
we_reg_state_o  out  1  state write enable
w_reg_state_addr_o  out  12  state write address
w_reg_state_data_o  out  18  state word {position[17:13], back_addr[12:1], over[0]}
done_o  out  1  one-cycle command-complete pulse
child_addr_o  out  12  address of the last child written, valid with done_o
wr_ptr_o  out  12  next free address
full_o  out  1  all DEPTH entries used
overflow_o  out  1  sticky: PUSH attempted while full

Function
REQ-003 SHALL have FSM states IDLE, WR_CHILD, WR_PARENT, WR_UPD; cmd_ready_o=1 only in IDLE with en_put_param==3'b010.
REQ-004 SHALL accept a command at the edge where cmd_valid_i & cmd_ready_o; all cmd_* fields are latched at that edge and ignored afterwards.
REQ-005 PUSH, not full: WR_CHILD writes InexRecur[wr_ptr]=param and state[wr_ptr]={5'd0, cmd_addr, 1'b0}, then increments the pointer; WR_PARENT writes state[cmd_addr]={pos+1, back_addr, over} and pulses done_o; the FSM then returns to IDLE.
REQ-006 PUSH position increment SHALL saturate at 31.
REQ-007 UPDATE: WR_UPD writes only state[cmd_addr]={position, back_addr, over}, pulses done_o, and returns to IDLE; the pointer is unchanged.
REQ-008 INIT: WR_CHILD writes root InexRecur[0]=param and state[0]={5'd0,12'd0,1'b0}; the pointer is set to 1; done_o pulses; WR_PARENT is skipped.
REQ-009 Latency: write strobes occur 1 cycle after acceptance (PUSH parent write after 2); done_o occurs in the last write cycle; each write enable is high for exactly one cycle.
REQ-010 A 13-bit internal count tracks used entries; full_o=(count==DEPTH); wr_ptr_o=count[11:0].
REQ-011 PUSH while full: no write strobes; overflow_o set; done_o pulses 1 cycle after acceptance; pointer unchanged.
REQ-012 Reserved op: no writes; done_o pulses 1 cycle after acceptance.
REQ-013 Deasserting en_put_param mid-command SHALL NOT abort the sequence; only new acceptance is blocked.
REQ-014 Write address/data outputs SHALL be registered and hold their last values when the enables are low.
REQ-015 overflow_o SHALL clear only on reset or an accepted INIT.

Reset
REQ-016 With rst_n low, all outputs and the count SHALL be 0 immediately, FSM=IDLE; cmd_ready_o follows REQ-003 after release.
REQ-017 Reset mid-sequence SHALL suppress any pending write; no write enable may assert during reset.

Structure
REQ-018 Op codes, FSM encodings, state-word field positions, ADDR_W and DEPTH SHALL live in the shared config include.
REQ-019 Single module; no sub-module.

Verification
REQ-020 INIT param=32'h01020304 -> cycle+1: InexRecur[0]=01020304, state[0]=0, wr_ptr_o=1, done_o=1.
REQ-021 PUSH param=32'hAABBCCDD, addr=0, back=0, pos=3, over=0 after INIT -> InexRecur[1]=AABBCCDD, state[1]={0,12'd0,0}; next cycle state[0]={5'd4,0,0}, done_o=1, child_addr_o=1.
REQ-022 UPDATE addr=5, pos=7, back=2, over=1 -> single state write at 5 = 18'h0E005, no InexRecur write, wr_ptr_o unchanged.
REQ-023 Fill to DEPTH with PUSHes, then one more PUSH -> full_o=1, overflow_o=1, no write enable; INIT then clears overflow_o and sets wr_ptr_o=1.
REQ-024 PUSH with pos=31 -> parent position written as 31.
REQ-025 Assert rst_n low during WR_CHILD -> no write enables, all outputs 0; cmd_ready_o=1 the first cycle after release when enabled.
